uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entry count, power of two, min 2.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-005 clks_per_bit  in  13  clock cycles per UART bit; values 0..1 treated as 2.
REQ-006 wr_data  in  DATA_WIDTH  byte to enqueue.
REQ-007 wr_en  in  1  enqueue strobe, one byte per high cycle.
REQ-008 full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-009 empty  out  1  FIFO holds 0 entries.
REQ-010 level  out  $clog2(FIFO_DEPTH)+1  current entry count.
REQ-011 overflow  out  1  one-cycle pulse when a write is dropped.
REQ-012 tx_data_bit  out  1  serial line, idle high.
REQ-013 busy  out  1  high from START entry through the last STOP cycle.
REQ-014 tx_done  out  1  one-cycle pulse on the final cycle of each stop bit.

Function
REQ-015 Frame SHALL be 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1); no parity.
REQ-016 Every bit SHALL hold the line for exactly N cycles, N = effective clks_per_bit latched on START entry; mid-frame changes to clks_per_bit SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START when !empty; START->DATA after N cycles; DATA->STOP after DATA_WIDTH bits; STOP->START if !empty at the final stop cycle, else STOP->IDLE.
REQ-018 On START entry the head entry SHALL be popped into a shift register (level decrements the same edge).
REQ-019 Latency: wr_en into an empty, idle block at edge k -> empty low after edge k; tx_data_bit low after edge k+1.
REQ-020 Back-to-back frames SHALL have no idle cycle between the stop bit and the next start bit.
REQ-021 Write with full==1 SHALL be dropped and pulse overflow, even if a pop occurs the same cycle; FIFO contents SHALL be unchanged.
REQ-022 Simultaneous write and pop when not full SHALL keep level unchanged and preserve order.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH or underflow.
REQ-024 full, empty, level SHALL be registered and reflect the state after the current edge.
REQ-025 tx_data_bit SHALL be driven from a register (glitch-free); 1 in IDLE and STOP.

Reset
REQ-026 rst low SHALL asynchronously force: FSM IDLE, pointers and level 0, empty=1, full=0, overflow=0, busy=0, tx_done=0, tx_data_bit=1.
REQ-027 Reset mid-frame SHALL abort the frame immediately (line high), discard all FIFO contents; no tx_done.
REQ-028 After rst release, the first write SHALL be accepted on the first rising edge.

Structure
REQ-029 FSM state encoding and the minimum-N constant (2) SHALL live in the shared uart package used by uart_rx/uart_tx.
REQ-030 Storage SHALL be a separate sub-module sync_fifo (parameterised DATA_WIDTH, FIFO_DEPTH) providing full/empty/level/overflow; serializer FSM stays in uart_tx_fifo.
REQ-031 Target size 120-400 lines of RTL total; no latches, no gated clocks.

Verification
REQ-032 clks_per_bit=4, write 0xA5 once -> line low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, high 4 cycles; tx_done pulses once; busy high for 40 cycles.
REQ-033 clks_per_bit=4, write 0x01,0x02,0x03 on consecutive cycles -> three 40-cycle frames contiguous (120 cycles), bytes in order, tx_done pulses at cycles 40/80/120 after first start.
REQ-034 FIFO_DEPTH=8, line busy, write 10 bytes consecutive -> first popped, 8 stored, full=1, 10th write drops with one overflow pulse; transmitted order intact.
REQ-035 clks_per_bit changed 4->8 mid-frame -> current frame completes at 4 cycles/bit, next frame uses 8.
REQ-036 rst asserted during DATA bit 3 -> tx_data_bit=1 and empty=1 asynchronously; after release, new write 0x5A transmits correctly.
REQ-037 clks_per_bit=0 -> each bit held 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding,
// bit-period constants and the effective-period helper.
package uart_pkg;

  localparam int unsigned CPB_W = 13;
  localparam int unsigned MIN_CLKS_PER_BIT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Periods below the minimum cannot form a bit; clamp them.
  function automatic logic [CPB_W-1:0] eff_cpb(
    input logic [CPB_W-1:0] c
  );
    if (c < CPB_W'(MIN_CLKS_PER_BIT)) begin
      return CPB_W'(MIN_CLKS_PER_BIT);
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty/level/overflow.
// Ports: wr_en/wr_data push, rd_en pop, rd_data shows head entry.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  // A write while full is dropped even if a pop
  // frees a slot on the same edge.
  assign push = wr_en && !full_q;
  assign pop  = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(FIFO_DEPTH));
    empty_d = (level_d == '0);
    ovf_d   = wr_en && full_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a sync_fifo: 8N1-style framing.
// Ports: wr_* enqueue, full/empty/level/overflow status, tx serial out.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CPB_W-1:0]            clks_per_bit,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        wr_en,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        tx_data_bit,
  output logic                        busy,
  output logic                        tx_done
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e state_q, state_d;

  logic [CPB_W-1:0]      cnt_q, cnt_d;
  logic [CPB_W-1:0]      n_q, n_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  pop;
  logic                  load;
  logic                  bit_end;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_head),
    .full     (full),
    .empty    (fifo_empty),
    .level    (level),
    .overflow (overflow)
  );

  assign bit_end = (cnt_q == n_q - CPB_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        load = !fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
        end else begin
          cnt_d = cnt_q + CPB_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CPB_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          load    = !fifo_empty;
        end else begin
          cnt_d = cnt_q + CPB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // START entry: pop head, latch the bit period,
    // drive the start bit on the same edge.
    if (load) begin
      state_d = START;
      cnt_d   = '0;
      n_d     = eff_cpb(clks_per_bit);
      sh_d    = fifo_head;
      tx_d    = 1'b0;
    end

    pop    = load;
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) &&
             (cnt_d == n_q - CPB_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= CPB_W'(MIN_CLKS_PER_BIT);
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign empty       = fifo_empty;
  assign tx_data_bit = tx_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table vectors,
// directed corner sequences and a serial-line scoreboard.
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [12:0]   clks_per_bit = 13'd4;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          full, empty, overflow;
  logic          tx_data_bit, busy, tx_done;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clks_per_bit (clks_per_bit),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .tx_data_bit  (tx_data_bit),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  typedef struct {
    logic [7:0] d;
    int         n;
  } exp_t;

  typedef struct {
    logic [12:0] cpb;
    logic [7:0]  d;
    int          n;
  } vec_t;

  exp_t sb[$];
  vec_t vt[6];

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int busy_rise = 0;
  int ovf_cnt = 0;
  logic busy_prev = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               name, act, req);
    end
  endtask

  task automatic clr_cnt();
    done_cnt  = 0;
    busy_cyc  = 0;
    busy_rise = 0;
    ovf_cnt   = 0;
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && empty === 1'b1 &&
          sb.size() == 0) break;
    end
    chk("drain_timeout", 32'(i >= budget), 32'd0);
  endtask

  // Event counters sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (tx_done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cyc++;
    if (busy === 1'b1 && busy_prev !== 1'b1)
      busy_rise++;
    busy_prev = busy;
    if (overflow === 1'b1) ovf_cnt++;
  end

  // Serial monitor: every bit must hold for exactly n cycles.
  task automatic run_frame();
    exp_t e;
    logic b_exp;
    logic act;
    int   dn;
    int   bbad;
    dn   = 0;
    bbad = 0;
    if (sb.size() == 0) begin
      chk("unexpected_frame", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      b_exp = 1'b0;
      else if (b == 9) b_exp = 1'b1;
      else             b_exp = e.d[b-1];
      act = b_exp;
      for (int c = 0; c < e.n; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (rst !== 1'b1) return;
        if (tx_data_bit !== b_exp) act = tx_data_bit;
        if (busy !== 1'b1) bbad++;
        if (tx_done === 1'b1) begin
          if (b == 9 && c == e.n - 1) dn++;
          else dn += 100;
        end
      end
      chk($sformatf("frame_%02h_bit%0d", e.d, b),
          32'(act), 32'(b_exp));
    end
    chk($sformatf("frame_%02h_done", e.d),
        32'(dn), 32'd1);
    chk($sformatf("frame_%02h_busy", e.d),
        32'(bbad), 32'd0);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst === 1'b1 && tx_data_bit === 1'b0)
      run_frame();
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{13'd0, 8'h3C, 2};
    vt[1] = '{13'd1, 8'hC3, 2};
    vt[2] = '{13'd2, 8'h00, 2};
    vt[3] = '{13'd3, 8'hFF, 3};
    vt[4] = '{13'd4, 8'hA5, 4};
    vt[5] = '{13'd7, 8'h81, 7};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx",    32'(tx_data_bit), 32'd1);
    chk("rst_empty", 32'(empty),       32'd1);
    chk("rst_full",  32'(full),        32'd0);
    chk("rst_level", 32'(level),       32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_done",  32'(tx_done),     32'd0);
    chk("rst_ovf",   32'(overflow),    32'd0);
    rst = 1'b1;

    // Single 0xA5 frame with latency checks
    @(negedge clk);
    clks_per_bit = 13'd4;
    clr_cnt();
    sb.push_back('{8'hA5, 4});
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("lat_empty", 32'(empty),       32'd0);
    chk("lat_level", 32'(level),       32'd1);
    chk("lat_tx_hi", 32'(tx_data_bit), 32'd1);
    @(negedge clk);
    chk("lat_tx_lo", 32'(tx_data_bit), 32'd0);
    chk("lat_pop",   32'(level),       32'd0);
    chk("lat_busy",  32'(busy),        32'd1);
    wait_idle(200);
    chk("a5_busy_cyc", 32'(busy_cyc), 32'd40);
    chk("a5_done_cnt", 32'(done_cnt), 32'd1);

    // Three back-to-back frames
    clr_cnt();
    sb.push_back('{8'h01, 4});
    sb.push_back('{8'h02, 4});
    sb.push_back('{8'h03, 4});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle(400);
    chk("b2b_busy_cyc",  32'(busy_cyc),  32'd120);
    chk("b2b_busy_rise", 32'(busy_rise), 32'd1);
    chk("b2b_done_cnt",  32'(done_cnt),  32'd3);

    // Ten writes: one popped, eight stored, one dropped
    clr_cnt();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(i);
      if (i < 9) sb.push_back('{8'h10 + 8'(i), 4});
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_full",  32'(full),     32'd1);
    chk("ovf_level", 32'(level),    32'd8);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    wait_idle(9 * 40 + 100);
    chk("ovf_cnt",      32'(ovf_cnt),  32'd1);
    chk("ovf_done_cnt", 32'(done_cnt), 32'd9);

    // Period change mid-frame
    clr_cnt();
    clks_per_bit = 13'd4;
    sb.push_back('{8'h3C, 4});
    wr(8'h3C);
    repeat (10) @(negedge clk);
    clks_per_bit = 13'd8;
    sb.push_back('{8'h96, 8});
    wr(8'h96);
    wait_idle(300);
    chk("cpb_busy_cyc", 32'(busy_cyc), 32'd120);

    // Period table, including clamped values
    foreach (vt[k]) begin
      clr_cnt();
      clks_per_bit = vt[k].cpb;
      sb.push_back('{vt[k].d, vt[k].n});
      wr(vt[k].d);
      wait_idle(10 * vt[k].n + 60);
      chk($sformatf("tbl%0d_busy_cyc", k),
          32'(busy_cyc), 32'(10 * vt[k].n));
      chk($sformatf("tbl%0d_done", k),
          32'(done_cnt), 32'd1);
    end

    // Reset during data bit 3
    clr_cnt();
    clks_per_bit = 13'd4;
    sb.push_back('{8'hC3, 4});
    wr(8'hC3);
    wr(8'h7E);
    repeat (16) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx",    32'(tx_data_bit), 32'd1);
    chk("arst_empty", 32'(empty),       32'd1);
    chk("arst_level", 32'(level),       32'd0);
    chk("arst_busy",  32'(busy),        32'd0);
    repeat (2) @(negedge clk);
    sb.delete();
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    sb.push_back('{8'h5A, 4});
    @(negedge clk);
    wr_en = 1'b0;
    chk("post_rst_wr", 32'(level), 32'd1);
    wait_idle(200);
    chk("post_rst_done", 32'(done_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
